// File: rtl/data_mem_responder_pkg.sv
// ============================================================================
// data_mem_responder_pkg : shared types for the data memory responder
// Rev 1.0
// ============================================================================
`default_nettype none

package data_mem_responder_pkg;

  // Width codes issued by the core's load/store path (funct3)
  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } load_store_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_rsp_state_e;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_mem_lane_align.sv
// ============================================================================
// mem_lane_align : byte-lane enables, store alignment and load extension
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_aligned,
  output logic [31:0] rdata_ext,
  output logic        align_err,
  output logic        code_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rword[{addr, 3'b000} +: 8];
  assign w_half = rword[{addr[1], 4'b0000} +: 16];

  always_comb begin
    byte_en       = 4'b0000;
    wdata_aligned = 32'h0;
    rdata_ext     = 32'h0;
    align_err     = 1'b0;
    code_err      = 1'b0;
    case (funct3)
      LS_B: begin
        byte_en       = 4'b0001 << addr;
        wdata_aligned = {4{wdata[7:0]}};
        rdata_ext     = {{24{w_byte[7]}}, w_byte};
      end
      LS_BU: begin
        rdata_ext = {24'h0, w_byte};
      end
      LS_H: begin
        byte_en       = addr[1] ? 4'b1100 : 4'b0011;
        wdata_aligned = {2{wdata[15:0]}};
        rdata_ext     = {{16{w_half[15]}}, w_half};
        align_err     = addr[0];
      end
      LS_HU: begin
        rdata_ext = {16'h0, w_half};
        align_err = addr[0];
      end
      LS_W: begin
        byte_en       = 4'b1111;
        wdata_aligned = wdata;
        rdata_ext     = rword;
        align_err     = (addr != 2'b00);
      end
      default: code_err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder : wait-stated load/store responder over a word RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int               IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] C_WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  mem_rsp_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic             w_commit;
  logic             w_use_req;
  logic             w_we;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic [2:0]       w_funct3;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rword;
  logic [3:0]       w_byte_en;
  logic [31:0]      w_wdata_aligned;
  logic [31:0]      w_rdata_ext;
  logic             w_align_err;
  logic             w_code_err;
  logic             w_range_err;
  logic             w_err;

  // With no wait states the commit happens on the accepting edge, so the
  // operation comes straight from the request port rather than the capture regs.
  assign w_use_req = (state_q == IDLE);
  assign w_we      = w_use_req ? req_we     : we_q;
  assign w_addr    = w_use_req ? req_addr   : addr_q;
  assign w_wdata   = w_use_req ? req_wdata  : wdata_q;
  assign w_funct3  = w_use_req ? req_funct3 : funct3_q;

  assign w_commit = ((state_q == WAIT) && (cnt_q == '0)) ||
                    ((state_q == IDLE) && req_valid && (WAIT_CYCLES == 0));

  assign w_idx       = w_addr[IDX_W+1:2];
  assign w_rword     = mem[w_idx];
  assign w_range_err = ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_err       = w_code_err | w_align_err | w_range_err | (w_we & w_funct3[2]);

  mem_lane_align u_lane (
    .funct3        (w_funct3),
    .addr          (w_addr[1:0]),
    .wdata         (w_wdata),
    .rword         (w_rword),
    .byte_en       (w_byte_en),
    .wdata_aligned (w_wdata_aligned),
    .rdata_ext     (w_rdata_ext),
    .align_err     (w_align_err),
    .code_err      (w_code_err)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = C_WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (w_commit) begin
      rdata_d = (w_err || w_we) ? 32'h0 : w_rdata_ext;
      err_d   = w_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'b000;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // RAM has no reset; a reset mid-WAIT suppresses the commit via state_q.
  always_ff @(posedge clk) begin
    if (w_commit && w_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byte_en[i]) mem[w_idx][8*i +: 8] <= w_wdata_aligned[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the core's load/store port. It accepts one request at a time over a valid/ready handshake and models WAIT_CYCLES wait states. It performs byte/halfword/word stores with byte-lane masking, and returns load data sign- or zero-extended from the addressed lane. It sits between the core's load/store path and the word-organised data RAM, and it is the target that decodes the load_store width codes the core issues.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words of storage; valid word index is addr[31:2] < DEPTH_WORDS.
WAIT_CYCLES, 2, wait states between request acceptance and response; legal range 0..15.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  responder can accept; high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
req_funct3  in  3  width code from the load_store enum in packages.
rsp_valid  out  1  response present.
rsp_ready  in  1  core accepts response.
rsp_rdata  out  32  load result, extended; 0 for stores and errors.
rsp_err  out  1  misaligned, illegal width, or out-of-range access.

Behaviour:
- Reset (async, rst_n=0): state goes to IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0; req_ready=1 after reset releases. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, capture we/addr/wdata/funct3 at the clock edge. Go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1); otherwise go to RESP.
  - WAIT: counter decrements each cycle; at 0 go to RESP.
  - RESP: rsp_valid=1, with rsp_rdata/rsp_err held stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE. There is no IDLE bypass: the next request is accepted one cycle after the handshake.
- Latency: if accepted at edge T, rsp_valid is high from cycle T+1+WAIT_CYCLES. Response backpressure is unbounded.
- Commit point: the RAM read/write happens on the transition into RESP. Read data is registered into rsp_rdata on that same edge.
- Width codes:
  - 000 byte (LB/SB); 001 half (LH/SH); 010 word (LW/SW); 100 LBU; 101 LHU.
  - Loads: 011, 110, 111 are illegal.
  - Stores: only 000/001/010 are legal.
- Error rules: any illegal code, half access with addr[0]=1, word access with addr[1:0]!=0, or addr[31:2] >= DEPTH_WORDS gives rsp_err=1 and rsp_rdata=0. No RAM write occurs on error.
- Store masks:
  - SB: lane addr[1:0], wdata[7:0] replicated.
  - SH: lanes {addr[1],0} and {addr[1],1}, wdata[15:0].
  - SW: all four lanes. Unmasked bytes are unchanged.
- Load extract: byte = word >> (8*addr[1:0]); half = word >> (16*addr[1]). LB/LH sign-extend; LBU/LHU zero-extend.
- Request inputs are ignored outside IDLE. req_valid may drop without acceptance.
- Reset mid-operation (in WAIT or RESP): the operation is dropped. A store still in WAIT is not written. A store already committed (in RESP) stays written.

Decomposition:
- packages gains the mem_rsp_state_e enum {IDLE, WAIT, RESP} (2 bits) and the constant MAX_WAIT=15.
- Width decode uses the existing load_store enum; no new literals.
- One combinational sub-module, mem_lane_align:
  - Inputs: funct3, addr[1:0], wdata, rword.
  - Outputs: byte_en[3:0], wdata_aligned, rdata_ext, align_err, code_err.
- The top module holds the FSM, wait counter, capture registers and RAM array.

Test Plan:
- Reset mid-WAIT: SW addr 0x20 data 0xDEADBEEF, assert rst_n=0 during WAIT. Then LW 0x20 returns previous content, not 0xDEADBEEF; outputs read 0 while reset is held.
- SW 0x10 0x11223344; SB 0x11 data 0xAA; LW 0x10 -> rdata 0x1122AA44, err 0. Latency check with WAIT_CYCLES=2: rsp_valid exactly 3 cycles after acceptance.
- SW 0x40 0x80FF7F01. Then:
  - LB 0x42 -> 0xFFFFFFFF
  - LBU 0x42 -> 0x000000FF
  - LH 0x42 -> 0xFFFF80FF
  - LHU 0x40 -> 0x00007F01
  - LB 0x40 -> 0x00000001
- Misaligned and illegal:
  - LH 0x41 -> err 1, rdata 0.
  - SW 0x42 0xFFFFFFFF -> err 1; a following LW 0x40 still returns 0x80FF7F01.
  - funct3=011 load -> err 1.
  - Out of range: LW 4*DEPTH_WORDS -> err 1.
- Backpressure: LW with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout. req_ready=1 one cycle after the handshake.
- WAIT_CYCLES=0 build: back-to-back requests with req_valid held high -> response each at T+1, one request accepted every 2 cycles minimum with rsp_ready=1.
